// File: rtl/ahb_manager_arbiter.sv
// rtl/ahb_manager_arbiter.sv - round-robin arbiter sharing one AHB-Lite manager port
// Single transfers only, one outstanding at a time; misaligned/oversized requests fail locally.
module ahb_manager_arbiter #(
  parameter int NUM_REQ = 2
) (
  input  logic                    HCLK,
  input  logic                    HRESETn,
  input  logic [NUM_REQ-1:0]      req_valid,
  output logic [NUM_REQ-1:0]      req_ready,
  input  logic [NUM_REQ*32-1:0]   req_addr,
  input  logic [NUM_REQ*32-1:0]   req_wdata,
  input  logic [NUM_REQ*3-1:0]    req_size,
  input  logic [NUM_REQ-1:0]      req_write,
  output logic [NUM_REQ-1:0]      rsp_valid,
  output logic [31:0]             rsp_rdata,
  output logic                    rsp_error,
  input  logic                    HREADY,
  input  logic [31:0]             HRDATA,
  input  logic                    HRESP,
  output logic [31:0]             HADDR,
  output logic [31:0]             HWDATA,
  output logic [2:0]              HSIZE,
  output logic [1:0]              HTRANS,
  output logic                    HWRITE
);

  localparam int CW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [1:0] TR_IDLE   = 2'b00;
  localparam logic [1:0] TR_NONSEQ = 2'b10;

  typedef enum logic [1:0] {ST_IDLE, ST_ADDR, ST_DATA, ST_LERR} state_t;

  state_t               r_state, w_state_nxt;
  logic [CW-1:0]        r_last, r_ch, w_win;
  logic                 w_found, w_illegal;
  logic [NUM_REQ-1:0]   w_cand;
  logic [31:0]          w_sel_addr, w_sel_wdata, r_wdata;
  logic [2:0]           w_sel_size;
  logic                 w_sel_write;
  logic [31:0]          r_haddr, r_hwdata, r_rdata;
  logic [2:0]           r_hsize;
  logic [1:0]           r_htrans;
  logic                 r_hwrite, r_error;
  logic [NUM_REQ-1:0]   r_rsp_valid;

  // A channel whose response pulse is showing this cycle sits out one round.
  assign w_cand = req_valid & ~r_rsp_valid;

  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      if (!w_found && w_cand[(int'(r_last) + k) % NUM_REQ]) begin
        w_found = 1'b1;
        w_win   = CW'((int'(r_last) + k) % NUM_REQ);
      end
    end
  end

  assign w_sel_addr  = req_addr[32*int'(w_win) +: 32];
  assign w_sel_wdata = req_wdata[32*int'(w_win) +: 32];
  assign w_sel_size  = req_size[3*int'(w_win) +: 3];
  assign w_sel_write = req_write[w_win];
  assign w_illegal   = (w_sel_size > 3'd2) ||
                       (w_sel_size == 3'd1 && w_sel_addr[0]) ||
                       (w_sel_size == 3'd2 && w_sel_addr[1:0] != 2'b00);

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) r_state <= ST_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    req_ready   = '0;
    case (r_state)
      ST_IDLE: begin
        if (w_found) begin
          req_ready[w_win] = 1'b1;
          w_state_nxt = w_illegal ? ST_LERR : ST_ADDR;
        end
      end
      ST_ADDR: if (HREADY) w_state_nxt = ST_DATA;
      ST_DATA: if (HREADY) w_state_nxt = ST_IDLE;
      ST_LERR: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_last      <= CW'(NUM_REQ - 1);
      r_ch        <= '0;
      r_wdata     <= '0;
      r_haddr     <= '0;
      r_hwdata    <= '0;
      r_hsize     <= '0;
      r_htrans    <= TR_IDLE;
      r_hwrite    <= 1'b0;
      r_rsp_valid <= '0;
      r_rdata     <= '0;
      r_error     <= 1'b0;
    end else begin
      r_rsp_valid <= '0;
      case (r_state)
        ST_IDLE: begin
          if (w_found) begin
            r_ch    <= w_win;
            r_wdata <= w_sel_wdata;
            if (!w_illegal) begin
              r_haddr  <= w_sel_addr;
              r_hsize  <= w_sel_size;
              r_hwrite <= w_sel_write;
              r_htrans <= TR_NONSEQ;
            end
          end
        end
        ST_ADDR: begin
          if (HREADY) begin
            r_htrans <= TR_IDLE;
            r_hwdata <= r_wdata;
          end
        end
        ST_DATA: begin
          if (HREADY) begin
            r_rsp_valid[r_ch] <= 1'b1;
            r_error           <= HRESP;
            r_rdata           <= r_hwrite ? 32'h0 : HRDATA;
            r_last            <= r_ch;
          end
        end
        ST_LERR: begin
          r_rsp_valid[r_ch] <= 1'b1;
          r_error           <= 1'b1;
          r_rdata           <= '0;
          r_last            <= r_ch;
        end
        default: ;
      endcase
    end
  end

  assign HADDR     = r_haddr;
  assign HWDATA    = r_hwdata;
  assign HSIZE     = r_hsize;
  assign HTRANS    = r_htrans;
  assign HWRITE    = r_hwrite;
  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rdata;
  assign rsp_error = r_error;

endmodule
